tile_pair_ctrl: RTL and testbench

//  Game sequencer for the memory-card board: owns the shown/covered state of N_TILES picture tiles.

---
 rtl/tile_pair_ctrl.sv | 151 +++++++++++++++
 tb/tb_tile_pair_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_pair_ctrl.sv
// Memory-card game sequencer: reveals at most two tiles, keeps matched pairs,
// and re-covers a mismatched pair after a fixed hold time.
module tile_pair_ctrl #(
  parameter int N_TILES     = 16,
  parameter int ID_W        = 3,
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_game,
  input  logic                      MouseLeft,
  input  logic                      hit_valid,
  input  logic [$clog2(N_TILES)-1:0] hit_idx,
  input  logic [N_TILES*ID_W-1:0]   pair_ids,
  output logic [N_TILES-1:0]        revealed,
  output logic [N_TILES-1:0]        matched,
  output logic [7:0]                moves,
  output logic                      busy,
  output logic                      game_done
);

  localparam int IW = $clog2(N_TILES);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [IW:0]   NT = (IW+1)'(N_TILES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ONE,
    S_CMP,
    S_HOLD,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [N_TILES-1:0]   rev_q, rev_d;
  logic [N_TILES-1:0]   mat_q, mat_d;
  logic [7:0]           moves_q, moves_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        ia_q, ia_d;
  logic [IW-1:0]        ib_q, ib_d;
  logic                 ml_q;

  logic                 click;
  logic [IW:0]          idx_ext;
  logic [ID_W-1:0]      id_a;
  logic [ID_W-1:0]      id_b;

  // Rising edge of the button over a covered, in-range tile
  always_comb begin
    idx_ext = {1'b0, hit_idx};
    click   = MouseLeft & ~ml_q & hit_valid & (idx_ext < NT)
            & ~rev_q[hit_idx] & ~mat_q[hit_idx];
    id_a    = pair_ids[int'(ia_q)*ID_W +: ID_W];
    id_b    = pair_ids[int'(ib_q)*ID_W +: ID_W];
  end

  // State and board registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rev_q   <= '0;
      mat_q   <= '0;
      moves_q <= '0;
      cnt_q   <= '0;
      ia_q    <= '0;
      ib_q    <= '0;
      ml_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rev_q   <= rev_d;
      mat_q   <= mat_d;
      moves_q <= moves_d;
      cnt_q   <= cnt_d;
      ia_q    <= ia_d;
      ib_q    <= ib_d;
      ml_q    <= MouseLeft;
    end
  end

  // Next-state: new_game overrides everything, else the game FSM
  always_comb begin
    state_d = state_q;
    rev_d   = rev_q;
    mat_d   = mat_q;
    moves_d = moves_q;
    cnt_d   = cnt_q;
    ia_d    = ia_q;
    ib_d    = ib_q;
    if (new_game) begin
      state_d = S_IDLE;
      rev_d   = '0;
      mat_d   = '0;
      moves_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (click) begin
            ia_d           = hit_idx;
            rev_d[hit_idx] = 1'b1;
            state_d        = S_ONE;
          end
        end
        S_ONE: begin
          if (click) begin
            ib_d           = hit_idx;
            rev_d[hit_idx] = 1'b1;
            if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
            state_d        = S_CMP;
          end
        end
        S_CMP: begin
          if (id_a == id_b) begin
            mat_d[ia_q] = 1'b1;
            mat_d[ib_q] = 1'b1;
            state_d     = (&mat_d) ? S_DONE : S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rev_d[ia_q] = 1'b0;
            rev_d[ib_q] = 1'b0;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    revealed  = rev_q;
    matched   = mat_q;
    moves     = moves_q;
    busy      = (state_q == S_CMP) || (state_q == S_HOLD);
    game_done = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_tile_pair_ctrl.sv
// Bench for tile_pair_ctrl: 16-tile board with a short hold,
// plus a 4-tile board for the game-complete path.
module tb_tile_pair_ctrl;

  typedef struct {
    logic        ml;
    logic        hv;
    logic [3:0]  idx;
    logic        ng;
    logic [15:0] rev;
    logic [15:0] mat;
    logic [7:0]  mv;
    logic        busy;
    logic        done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        MouseLeft = 1'b0;
  logic        hit_valid = 1'b0;
  logic [3:0]  hit_idx = '0;
  logic        new_game = 1'b0;
  logic [47:0] pidA;
  logic [15:0] revealed, matched;
  logic [7:0]  moves;
  logic        busy, game_done;

  logic        mlB = 1'b0;
  logic        hvB = 1'b0;
  logic [1:0]  idxB = '0;
  logic        ngB = 1'b0;
  logic [11:0] pidB;
  logic [3:0]  revB, matB;
  logic [7:0]  movesB;
  logic        busyB, doneB;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  tile_pair_ctrl #(.N_TILES(16), .ID_W(3), .HOLD_CYCLES(10)) dut_a (
    .clk(clk), .rst(rst), .new_game(new_game), .MouseLeft(MouseLeft),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .pair_ids(pidA),
    .revealed(revealed), .matched(matched), .moves(moves),
    .busy(busy), .game_done(game_done)
  );

  tile_pair_ctrl #(.N_TILES(4), .ID_W(3), .HOLD_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .new_game(ngB), .MouseLeft(mlB),
    .hit_valid(hvB), .hit_idx(idxB), .pair_ids(pidB),
    .revealed(revB), .matched(matB), .moves(movesB),
    .busy(busyB), .game_done(doneB)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ml, input logic hv,
                              input logic [3:0] idx, input logic ng,
                              input logic [15:0] rev, input logic [15:0] mat,
                              input logic [7:0] mv, input logic b,
                              input logic d);
    vec_t v;
    v.ml = ml; v.hv = hv; v.idx = idx; v.ng = ng;
    v.rev = rev; v.mat = mat; v.mv = mv; v.busy = b; v.done = d;
    return v;
  endfunction

  task automatic drv(input logic ml, input logic hv,
                     input logic [3:0] idx, input logic ng);
    MouseLeft = ml; hit_valid = hv; hit_idx = idx; new_game = ng;
    @(posedge clk); #1;
  endtask

  task automatic step(input vec_t v, input string nm);
    vec_t e;
    exp_q.push_back(v);
    drv(v.ml, v.hv, v.idx, v.ng);
    e = exp_q.pop_front();
    chk({nm, ".rev"}, 32'(revealed), 32'(e.rev));
    chk({nm, ".mat"}, 32'(matched), 32'(e.mat));
    chk({nm, ".moves"}, 32'(moves), 32'(e.mv));
    chk({nm, ".busy"}, 32'(busy), 32'(e.busy));
    chk({nm, ".done"}, 32'(game_done), 32'(e.done));
  endtask

  task automatic drvB(input logic ml, input logic [1:0] idx, input logic ng);
    mlB = ml; hvB = 1'b1; idxB = idx; ngB = ng;
    @(posedge clk); #1;
  endtask

  task automatic clickB(input logic [1:0] idx);
    drvB(1'b1, idx, 1'b0);
    drvB(1'b0, idx, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < 16; i++) pidA[i*3 +: 3] = 3'((i/2 + 3) % 8);
    pidB = {3'd2, 3'd1, 3'd2, 3'd1};

    tbl[0]  = mk(1, 1, 0, 0, 16'h0001, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 16'h0001, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 0, 16'h0003, 16'h0000, 1, 1, 0);
    tbl[3]  = mk(0, 1, 1, 0, 16'h0003, 16'h0003, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[5]  = mk(1, 1, 4, 0, 16'h0010, 16'h0000, 0, 0, 0);
    tbl[6]  = mk(1, 1, 6, 0, 16'h0010, 16'h0000, 0, 0, 0);
    tbl[7]  = mk(1, 1, 4, 0, 16'h0010, 16'h0000, 0, 0, 0);
    tbl[8]  = mk(0, 1, 4, 0, 16'h0010, 16'h0000, 0, 0, 0);
    tbl[9]  = mk(1, 1, 4, 0, 16'h0010, 16'h0000, 0, 0, 0);
    tbl[10] = mk(0, 1, 4, 0, 16'h0010, 16'h0000, 0, 0, 0);
    tbl[11] = mk(1, 0, 7, 0, 16'h0010, 16'h0000, 0, 0, 0);
    tbl[12] = mk(0, 1, 7, 0, 16'h0010, 16'h0000, 0, 0, 0);

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst.rev", 32'(revealed), 0);
    chk("rst.mat", 32'(matched), 0);
    chk("rst.moves", 32'(moves), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(game_done), 0);
    chk("rst.revB", 32'(revB), 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // match, edge detection, ignored clicks
    for (int i = 0; i < 13; i++) step(tbl[i], $sformatf("vec%0d", i));

    // button held over tile 4 for 50 cycles
    for (int i = 0; i < 50; i++)
      step(mk(1, 1, 4, 0, 16'h0010, 0, 0, 0, 0), "hold50");
    step(mk(0, 1, 4, 0, 16'h0010, 0, 0, 0, 0), "hold50.rel");

    // mismatch 4/7: visible 11 samples, click on 9 during and at terminal
    step(mk(1, 1, 7, 0, 16'h0090, 0, 1, 1, 0), "mis.b");
    for (int k = 1; k <= 11; k++)
      step(mk((k == 3 || k == 10), 1, 9, 0,
              (k <= 10) ? 16'h0090 : 16'h0000, 0, 1, (k <= 10), 0),
           $sformatf("hold%0d", k));
    step(mk(0, 1, 9, 0, 16'h0000, 0, 1, 0, 0), "hold.after");

    // async reset in the middle of HOLD with tiles 2,5 shown
    step(mk(1, 1, 2, 0, 16'h0004, 0, 1, 0, 0), "r.a");
    step(mk(0, 1, 2, 0, 16'h0004, 0, 1, 0, 0), "r.rel");
    step(mk(1, 1, 5, 0, 16'h0024, 0, 2, 1, 0), "r.b");
    step(mk(0, 1, 5, 0, 16'h0024, 0, 2, 1, 0), "r.hold");
    #2 rst = 1'b0;
    #1;
    chk("arst.rev", 32'(revealed), 0);
    chk("arst.moves", 32'(moves), 0);
    chk("arst.busy", 32'(busy), 0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    step(mk(1, 1, 2, 0, 16'h0004, 0, 0, 0, 0), "arst.idle");
    step(mk(0, 1, 2, 0, 16'h0004, 0, 0, 0, 0), "arst.rel");

    // 256 mismatches, moves saturates
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0), "sat.ng");
    for (int n = 1; n <= 256; n++) begin
      drv(1, 1, 2, 0); drv(0, 1, 2, 0);
      drv(1, 1, 5, 0); drv(0, 1, 5, 0);
      w = 0;
      while (busy && w < 20) begin drv(0, 0, 0, 0); w++; end
      chk($sformatf("sat.idle%0d", n), 32'(busy), 0);
      chk($sformatf("sat.moves%0d", n), 32'(moves), (n > 255) ? 255 : n);
    end
    step(mk(1, 1, 0, 1, 0, 0, 0, 0, 0), "ng.click");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0), "ng.after");

    // 4-tile board: complete the game
    clickB(2'd0); clickB(2'd2);
    chk("b.mat1", 32'(matB), 32'h5);
    chk("b.rev1", 32'(revB), 32'h5);
    chk("b.done1", 32'(doneB), 0);
    clickB(2'd1); clickB(2'd3);
    chk("b.mat2", 32'(matB), 32'hF);
    chk("b.done2", 32'(doneB), 1);
    chk("b.moves", 32'(movesB), 2);
    chk("b.busy", 32'(busyB), 0);
    clickB(2'd1);
    chk("b.frozen", 32'(revB), 32'hF);
    chk("b.frozenmv", 32'(movesB), 2);
    drvB(1'b0, 2'd0, 1'b1);
    chk("b.ng.rev", 32'(revB), 0);
    chk("b.ng.mat", 32'(matB), 0);
    chk("b.ng.done", 32'(doneB), 0);
    chk("b.ng.moves", 32'(movesB), 0);
    drvB(1'b0, 2'd0, 1'b0);
    clickB(2'd3);
    chk("b.idle", 32'(revB), 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
